// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host transmitter and line filter.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_t;

    // Transmit frame: {stop, parity, data[7:0]}; the start bit is driven separately.
    localparam int unsigned FRAME_W = 10;
    localparam int unsigned BIT_W   = 4;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    // Bits needed to hold the value max_val.
    function automatic int unsigned cnt_w(input longint unsigned max_val);
        return (max_val < 64'd2) ? 1 : int'($clog2(max_val + 64'd1));
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer plus stability filter for a PS/2 line; emits a one-cycle
// pulse when the filtered level falls.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic reset_n_i,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int unsigned CNT_W = cnt_w(64'(FILTER_CYCLES));

    logic             meta_q;
    logic             sync_q;
    logic             level_q;
    logic             fall_q;
    logic [CNT_W-1:0] cnt_q;

    // Count consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            fall_q <= 1'b0;
            if (sync_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
                level_q <= sync_q;
                fall_q  <= level_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits,
// odd parity, stop and device ack, with an overall timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned FREQ_HZ       = 30_000_000,
    parameter int unsigned INHIBIT_US    = 100,
    parameter int unsigned TIMEOUT_MS    = 15,
    parameter int unsigned FILTER_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset_n_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       ack_o,
    output logic       err_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o
);

    localparam longint unsigned INHIBIT_CYC = 64'(INHIBIT_US) * 64'(FREQ_HZ) / 64'd1_000_000;
    localparam longint unsigned TIMEOUT_CYC = 64'(TIMEOUT_MS) * 64'(FREQ_HZ) / 64'd1_000;
    localparam int unsigned     TMR_W       =
        cnt_w((INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC);

    ps2_tx_state_t        state_q, state_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic                 clk_oe_q, clk_oe_d;
    logic                 data_oe_q, data_oe_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 ack_smp_q, ack_smp_d;
    logic                 data_meta_q, data_sync_q;
    logic                 clk_level;
    logic                 clk_fall;
    logic                 timeout;

    ps2_line_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_clk_filter (
        .clk      (clk),
        .reset_n_i(reset_n_i),
        .line_i   (ps2_clk_i),
        .level_o  (clk_level),
        .fall_o   (clk_fall)
    );

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_q       <= '0;
            tmr_q       <= '0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            ack_smp_q   <= 1'b0;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_q       <= bit_d;
            tmr_q       <= tmr_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            ack_smp_q   <= ack_smp_d;
            data_meta_q <= ps2_data_i;
            data_sync_q <= data_meta_q;
        end
    end

    // The same timer paces the inhibit phase and then the whole device phase.
    assign timeout = (state_q inside {REQ, DATA, ACK, WAIT_IDLE}) &&
                     (tmr_q == TMR_W'(TIMEOUT_CYC - 64'd1));

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        tmr_d     = tmr_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_d     = ack_q;
        err_d     = err_q;
        ack_smp_d = ack_smp_q;

        if (state_q inside {REQ, DATA, ACK, WAIT_IDLE}) begin
            tmr_d = tmr_q + TMR_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (valid_i && ready_q) begin
                    shift_d   = {1'b1, odd_parity(data_i), data_i};
                    tmr_d     = '0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (tmr_q == TMR_W'(INHIBIT_CYC - 64'd1)) begin
                    data_oe_d = 1'b1;
                end
                if (tmr_q == TMR_W'(INHIBIT_CYC)) begin
                    clk_oe_d = 1'b0;
                    tmr_d    = '0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                bit_d   = '0;
                state_d = DATA;
            end
            DATA: begin
                if (clk_fall) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b0, shift_q[FRAME_W-1:1]};
                    bit_d     = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(FRAME_W - 1)) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                if (clk_fall) begin
                    ack_smp_d = ~data_sync_q;
                    state_d   = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_level && data_sync_q) begin
                    done_d  = 1'b1;
                    ack_d   = ack_smp_q;
                    err_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Timeout overrides any bit activity seen in the same cycle.
        if (timeout) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b1;
            ack_d     = 1'b0;
            err_d     = 1'b1;
            busy_d    = 1'b0;
            state_d   = IDLE;
        end
    end

    assign ready_o       = ready_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign ack_o         = ack_q;
    assign err_o         = err_q;
    assign ps2_clk_oe_o  = clk_oe_q;
    assign ps2_data_oe_o = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain device model, cycle-level output model, frame checks.
module tb_ps2_host_tx;

    localparam int unsigned FREQ   = 3_000_000;
    localparam int unsigned INH_US = 100;
    localparam int unsigned TO_MS  = 2;
    localparam int unsigned FILT   = 8;
    localparam int          INH    = INH_US * (FREQ / 1_000_000);
    localparam int          TO     = TO_MS * (FREQ / 1_000);
    localparam int          HALF   = FREQ / 25_000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o, busy_o, done_o, ack_o, err_o;
    logic       clk_oe_o, data_oe_o;
    logic       dev_clk_low, dev_data_low, glitch;
    wire        ps2_clk  = !(clk_oe_o || dev_clk_low || glitch);
    wire        ps2_data = !(data_oe_o || dev_data_low);

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int dev_end  = -1;
    bit exp_ack, exp_err;
    bit chk_en   = 1'b0;

    bit m_busy = 1'b0, m_ready = 1'b1, m_ack = 1'b0, m_err = 1'b0;
    bit pend_rst = 1'b1, pend_acc = 1'b0, pend_ready = 1'b0;
    int m_s = 0;

    ps2_host_tx #(
        .FREQ_HZ(FREQ), .INHIBIT_US(INH_US), .TIMEOUT_MS(TO_MS), .FILTER_CYCLES(FILT)
    ) dut (
        .clk(clk), .reset_n_i(reset_n), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o), .ack_o(ack_o), .err_o(err_o),
        .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data),
        .ps2_clk_oe_o(clk_oe_o), .ps2_data_oe_o(data_oe_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame as seen by the device, index 0 = start bit, 10 = stop bit.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        return {1'b1, ($countones(b) % 2 == 0), b, 1'b0};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Cycle model of the handshake and line enables, sampled mid-cycle.
    always @(negedge clk) begin
        bit to_now;
        if (chk_en) begin
            if (pend_rst) begin
                m_busy = 0; m_ready = 1; m_s = 0; m_ack = 0; m_err = 0; pend_ready = 0;
            end else begin
                if (pend_ready) begin m_ready = 1; pend_ready = 0; end
                if (pend_acc) begin m_busy = 1; m_ready = 0; m_s = 1; end
                else if (m_busy) m_s++;
            end
            to_now = m_busy && exp_err && (m_s == INH + 2 + TO);
            if (to_now && !done_o) begin
                check("timeout_done", 32'(done_o), 1);
                m_busy = 0; pend_ready = 1; m_ack = 0; m_err = 1;
            end
            if (done_o) begin
                check("done_in_xfer", 32'(m_busy), 1);
                if (exp_err) check("timeout_cycle", m_s, INH + 2 + TO);
                else check("done_after_dev", 32'(dev_end >= 0 && cyc - dev_end >= 1 &&
                                                  cyc - dev_end <= int'(FILT) + 10), 1);
                check("ack_at_done", 32'(ack_o), 32'(exp_ack));
                check("err_at_done", 32'(err_o), 32'(exp_err));
                m_ack = exp_ack; m_err = exp_err; m_busy = 0; pend_ready = 1;
            end else begin
                check("ack_hold", 32'(ack_o), 32'(m_ack));
                check("err_hold", 32'(err_o), 32'(m_err));
            end
            check("ready", 32'(ready_o), 32'(m_ready));
            check("busy", 32'(busy_o), 32'(m_busy));
            if (!m_busy || m_s > INH + 1) check("clk_oe_rel", 32'(clk_oe_o), 0);
            else check("clk_oe_inh", 32'(clk_oe_o), 1);
            if (!m_busy) check("data_oe_rel", 32'(data_oe_o), 0);
            else if (m_s <= INH) check("data_oe_inh", 32'(data_oe_o), 0);
            else if (m_s <= INH + 2) check("data_oe_start", 32'(data_oe_o), 1);
            pend_rst = !reset_n;
            pend_acc = reset_n && valid_i && m_ready;
        end
    end

    // Device side: clocks at 12.5 kHz, samples data on rising edges.
    task automatic dev_xfer(input bit do_ack, input bit glitch_en, input int stop_after,
                            output logic [10:0] fr);
        int n = 0;
        fr = '0;
        while (!(clk_oe_o == 1'b0 && data_oe_o == 1'b1) && n < INH + 20) begin
            tick(1); n++;
        end
        check("req_seen", 32'(clk_oe_o == 1'b0 && data_oe_o == 1'b1), 1);
        tick(30);
        fr[0] = ps2_data;
        for (int k = 1; k <= 10; k++) begin
            dev_clk_low = 1'b1;
            tick(HALF);
            dev_clk_low = 1'b0;
            if (k == stop_after) return;
            fr[k] = ps2_data;
            if (k == 10) begin
                tick(HALF / 2);
                dev_data_low = do_ack;
                tick(HALF - HALF / 2);
            end else if (glitch_en) begin
                tick(40); glitch = 1'b1; tick(3); glitch = 1'b0; tick(HALF - 43);
            end else begin
                tick(HALF);
            end
        end
        dev_clk_low = 1'b1;
        tick(HALF);
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        dev_end = cyc;
    endtask

    task automatic wait_done(input int limit, output bit got, output int at);
        got = 0; at = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done_o) begin got = 1; at = cyc; break; end
        end
        check("done_seen", 32'(got), 1);
    endtask

    task automatic run_xfer(input logic [7:0] b, input bit do_ack, input bit glitch_en,
                            input bit hold_valid, output logic [10:0] fr);
        bit got; int at;
        exp_ack = do_ack; exp_err = 0; dev_end = -1;
        data_i = b; valid_i = 1'b1;
        tick(1);
        if (hold_valid) data_i = 8'hAA; else valid_i = 1'b0;
        dev_xfer(do_ack, glitch_en, 11, fr);
        wait_done(FILT + 40, got, at);
        tick(1);
        valid_i = 1'b0;
        check("frame", 32'(fr), 32'(exp_frame(b)));
        tick(2);
    endtask

    initial begin
        logic [10:0] fr;
        logic [7:0]  rb;
        bit got; int at, acc;
        reset_n = 1'b0; valid_i = 1'b0; data_i = '0;
        dev_clk_low = 1'b0; dev_data_low = 1'b0; glitch = 1'b0;
        exp_ack = 0; exp_err = 0;
        tick(3);
        chk_en = 1'b1;
        check("rst_ready", 32'(ready_o), 1);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_ack_err", 32'({ack_o, err_o}), 0);
        check("rst_oe", 32'({clk_oe_o, data_oe_o}), 0);
        tick(1);
        reset_n = 1'b1;
        tick(2);

        run_xfer(8'hED, 1'b1, 1'b0, 1'b0, fr);
        check("frame_ED_literal", 32'(fr), 32'(11'b11111011010));
        check("ack_ED", 32'(ack_o), 1);

        run_xfer(8'hF4, 1'b0, 1'b0, 1'b0, fr);
        check("parity_F4", 32'(fr[9]), 0);
        check("noack_F4", 32'({ack_o, err_o}), 0);

        // Device never clocks: expect timeout.
        exp_ack = 0; exp_err = 1; dev_end = -1;
        data_i = 8'h3C; valid_i = 1'b1;
        tick(1);
        acc = cyc; valid_i = 1'b0;
        wait_done(INH + TO + 50, got, at);
        check("timeout_len", at - acc, 6301);
        check("timeout_oe", 32'({clk_oe_o, data_oe_o}), 0);
        check("timeout_err", 32'({ack_o, err_o}), 32'(2'b01));
        tick(2);

        run_xfer(8'h3B, 1'b1, 1'b0, 1'b1, fr);
        run_xfer(8'h96, 1'b1, 1'b1, 1'b0, fr);

        // Reset after the fourth falling edge of a transfer.
        exp_ack = 0; exp_err = 0; dev_end = -1;
        data_i = 8'h5A; valid_i = 1'b1;
        tick(1);
        valid_i = 1'b0;
        dev_xfer(1'b0, 1'b0, 4, fr);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check("abort_oe", 32'({clk_oe_o, data_oe_o}), 0);
        check("abort_ready", 32'(ready_o), 1);
        check("abort_done", 32'(done_o), 0);
        tick(2);
        run_xfer(8'hF4, 1'b1, 1'b0, 1'b0, fr);
        check("after_abort_ack", 32'(ack_o), 1);

        for (int t = 0; t < 3; t++) begin
            rb = 8'($urandom);
            run_xfer(rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, fr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
